button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 23 ++
 rtl/button_conditioner_if.sv | 27 ++
 rtl/debounce_channel.sv | 70 +++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning front end.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int NUM_BTN_DEFAULT         = 3;

    // Channel indices as wired on the lab adder/logic top level
    localparam int BTN_LOADB = 0;
    localparam int BTN_RUN   = 1;
    localparam int BTN_SPARE = 2;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } btn_state_e;

    // Buttons are wired active-low: a 0 on the pin means the button is held
    function automatic logic level_held(input logic level_n);
        return ~level_n;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw button levels and their conditioned levels/strobes.
interface button_conditioner_if
    import btn_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT
);

    logic [NUM_BTN-1:0] btn_n;
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] release_pulse;

    modport master (
        output btn_n,
        input  pressed,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_n,
        output pressed,
        output press_pulse,
        output release_pulse
    );

endinterface

// File: rtl/debounce_channel.sv
// One button: two-flop synchronizer, stability counter, debounced level and
// registered single-cycle press/release strobes.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    btn_state_e       state;
    btn_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Synchronizers reset to the released level so reset exit never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            state         <= ST_RELEASED;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn_n;
            sync2         <= sync1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Any sample that agrees with the stable level restarts the count
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (level_held(sync2) != (state == ST_HELD)) begin
            if (cnt == CNT_MAX) begin
                if (state == ST_HELD) begin
                    state_nxt   = ST_RELEASED;
                    release_nxt = 1'b1;
                end else begin
                    state_nxt = ST_HELD;
                    press_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign pressed = (state == ST_HELD);

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw active-low buttons into clean levels and strobes,
// one independent debounce_channel per button.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] btn_n_w;
    logic [NUM_BTN-1:0] pressed_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;

    assign btn_n_w = bus.btn_n;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_n         (btn_n_w[i]),
            .pressed       (pressed_w[i]),
            .press_pulse   (press_w[i]),
            .release_pulse (release_w[i])
        );
    end

    assign bus.pressed       = pressed_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with a 4-sample debounce window.
module tb_button_conditioner;
    import btn_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    button_conditioner_if #(.NUM_BTN(3)) bus ();

    button_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.btn_n = 3'b111;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        int pulses_seen;
        rst_n = 1'b0;
        bus.btn_n = 3'b000;
        #2;
        checks++;
        if (bus.pressed !== 3'b000 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_async outputs got %b/%b/%b exp 000/000/000",
                     bus.pressed, bus.press_pulse, bus.release_pulse);
        end
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (bus.pressed !== 3'b000 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_held outputs got %b/%b/%b exp 000/000/000",
                     bus.pressed, bus.press_pulse, bus.release_pulse);
        end
        bus.btn_n = 3'b111;
        rst_n = 1'b1;
        pulses_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (bus.pressed != 3'b000 || bus.press_pulse != 3'b000 || bus.release_pulse != 3'b000)
                pulses_seen++;
        end
        checks++;
        if (pulses_seen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_exit activity cycles got %0d exp 0", pulses_seen);
        end
    endtask

    task automatic test_clean_press;
        logic [2:0] exp_pressed;
        logic [2:0] exp_press;
        do_reset();
        bus.btn_n = 3'b101;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_pressed = (k >= 6) ? 3'b010 : 3'b000;
            exp_press   = (k == 6) ? 3'b010 : 3'b000;
            checks++;
            if (bus.pressed !== exp_pressed) begin
                errors++;
                $display("[TB] FAIL clean_press.pressed k=%0d got %b exp %b", k, bus.pressed, exp_pressed);
            end
            checks++;
            if (bus.press_pulse !== exp_press) begin
                errors++;
                $display("[TB] FAIL clean_press.press_pulse k=%0d got %b exp %b", k, bus.press_pulse, exp_press);
            end
            checks++;
            if (bus.release_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL clean_press.release_pulse k=%0d got %b exp 000", k, bus.release_pulse);
            end
        end
    endtask

    // Bounce on channel 0, then a real press, then its release
    task automatic test_bounce_and_release;
        logic [11:0] pattern;
        logic [2:0]  exp_pressed;
        logic [2:0]  exp_press;
        logic [2:0]  exp_release;
        do_reset();
        pattern = 12'b000100011111;
        for (int k = 0; k < 12; k++) begin
            bus.btn_n[0] = pattern[11-k];
            step();
            checks++;
            if (bus.pressed !== 3'b000 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL bounce k=%0d got %b/%b/%b exp 000/000/000",
                         k, bus.pressed, bus.press_pulse, bus.release_pulse);
            end
        end
        bus.btn_n[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_pressed = (k >= 6) ? 3'b001 : 3'b000;
            exp_press   = (k == 6) ? 3'b001 : 3'b000;
            checks++;
            if (bus.pressed !== exp_pressed || bus.press_pulse !== exp_press || bus.release_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL bounce_hold k=%0d got %b/%b/%b exp %b/%b/000",
                         k, bus.pressed, bus.press_pulse, bus.release_pulse, exp_pressed, exp_press);
            end
        end
        bus.btn_n[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_pressed = (k < 6) ? 3'b001 : 3'b000;
            exp_release = (k == 6) ? 3'b001 : 3'b000;
            checks++;
            if (bus.pressed !== exp_pressed || bus.release_pulse !== exp_release || bus.press_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL release k=%0d got %b/%b/%b exp %b/000/%b",
                         k, bus.pressed, bus.press_pulse, bus.release_pulse, exp_pressed, exp_release);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [2:0] exp_pressed;
        logic [2:0] exp_press;
        do_reset();
        bus.btn_n = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_pressed = (k >= 6) ? 3'b111 : 3'b000;
            exp_press   = (k == 6) ? 3'b111 : 3'b000;
            checks++;
            if (bus.pressed !== exp_pressed || bus.press_pulse !== exp_press || bus.release_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL simultaneous k=%0d got %b/%b/%b exp %b/%b/000",
                         k, bus.pressed, bus.press_pulse, bus.release_pulse, exp_pressed, exp_press);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        logic [2:0] exp_pressed;
        logic [2:0] exp_press;
        do_reset();
        bus.btn_n = 3'b011;
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.pressed !== 3'b000 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL mid_reset k=%0d got %b/%b/%b exp 000/000/000",
                         k, bus.pressed, bus.press_pulse, bus.release_pulse);
            end
            if (k < 2) step();
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_pressed = (k >= 6) ? 3'b100 : 3'b000;
            exp_press   = (k == 6) ? 3'b100 : 3'b000;
            checks++;
            if (bus.pressed !== exp_pressed || bus.press_pulse !== exp_press || bus.release_pulse !== 3'b000) begin
                errors++;
                $display("[TB] FAIL after_mid_reset k=%0d got %b/%b/%b exp %b/%b/000",
                         k, bus.pressed, bus.press_pulse, bus.release_pulse, exp_pressed, exp_press);
            end
        end
    endtask

    task automatic test_long_hold;
        int press_cnt;
        int release_cnt;
        int first_pulse;
        int drops;
        do_reset();
        press_cnt   = 0;
        release_cnt = 0;
        first_pulse = -1;
        drops       = 0;
        bus.btn_n = 3'b101;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (bus.press_pulse[1] === 1'b1) begin
                press_cnt++;
                if (first_pulse < 0) first_pulse = k;
            end
            if (bus.release_pulse !== 3'b000) release_cnt++;
            if (k >= 6 && bus.pressed !== 3'b010) drops++;
        end
        checks++;
        if (press_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL long_hold.press_count got %0d exp 1", press_cnt);
        end
        checks++;
        if (first_pulse !== 6) begin
            errors++;
            $display("[TB] FAIL long_hold.pulse_cycle got %0d exp 6", first_pulse);
        end
        checks++;
        if (release_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL long_hold.release_count got %0d exp 0", release_cnt);
        end
        checks++;
        if (drops !== 0) begin
            errors++;
            $display("[TB] FAIL long_hold.pressed_drops got %0d exp 0", drops);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.btn_n = 3'b111;
        test_reset();
        test_clean_press();
        test_bounce_and_release();
        test_simultaneous();
        test_reset_mid_count();
        test_long_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
